prio_read_scheduler: RTL and testbench
======================================

# prio_read_scheduler

Read-side scheduler for a bank of NUM_Q priority FIFOs (21-bit entries, standard non-first-word-fall-through read). Chooses one non-empty queue per transaction by strict priority (queue 0 highest), with an aging guard against starvation of lower queues. Issues the single-cycle read pulse and waits out the FIFO read latency. Captures the word and presents it to the downstream switch stage on a valid/ready handshake.

## Interface
- NUM_Q, 4: number of queues; range 2..8.
- DATA_W, 21: FIFO entry width.
- RD_LAT, 1: cycles from the edge that samples q_re to the edge at which q_dout holds the read word; range 1..4.
- STARVE_LIM, 8: grants to other queues that a waiting non-empty queue tolerates before forced promotion; 0 disables aging. Width of the age counters is 4 bits.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- q_empty  in  NUM_Q  per-queue empty flag; bit i belongs to queue i.
- q_dout  in  NUM_Q*DATA_W  per-queue read data; queue i occupies bits [i*DATA_W +: DATA_W].
- q_re  out  NUM_Q  one-hot read pulse, registered.
- out_valid  out  1  out_data/out_qid hold a captured word.
- out_ready  in  1  downstream accepts the word when high together with out_valid.
- out_data  out  DATA_W  captured word.
- out_qid  out  3  index of the source queue; upper bits are 0 when NUM_Q < 8.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ, WAIT, HOLD. Reset state is IDLE.
- Selection function SEL:
  - If STARVE_LIM > 0 and any non-empty queue has age == STARVE_LIM, pick the lowest such index.
  - Otherwise pick the lowest-index queue with q_empty = 0.
  - None if all queues are empty.
- IDLE:
  - If SEL exists: latch grant g = SEL and go to READ.
  - Otherwise stay in IDLE.
- READ:
  - q_re[g] = 1 for exactly this one cycle.
  - Load the latency counter with RD_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle it reaches 1, register q_dout[g] into out_data and g into out_qid, then go to HOLD.
- HOLD:
  - out_valid = 1. out_data and out_qid hold stable until the handshake.
  - On out_ready = 1: if SEL exists, latch the new g and go to READ (back-to-back). Otherwise go to IDLE.
- Aging:
  - Ages update only at a grant latch.
  - Granted queue: age cleared to 0.
  - Every other non-empty queue: age incremented, saturating at STARVE_LIM.
  - Any queue sampled empty at that point: age cleared to 0.
- q_empty is evaluated only in IDLE and at the HOLD handshake, i.e. at least RD_LAT+1 cycles after the last q_re. This ensures the FIFO's empty flag already reflects the prior read.
- q_re is never asserted to a queue that was sampled empty. The scheduler never holds more than one read outstanding.

## Timing
- Reset values:
  - q_re = 0, out_valid = 0, out_data = 0, out_qid = 0, busy = 0.
  - All age counters = 0, latency counter = 0, state = IDLE.
- Asynchronous rst mid-transaction aborts it immediately. A word already popped from a FIFO is discarded; the system resets the FIFOs on the same rst.
- Latency, with cycle 0 = IDLE cycle where SEL is found:
  - cycle 1: q_re.
  - cycle 1+RD_LAT: capture edge.
  - cycle 2+RD_LAT: out_valid rises.
- With RD_LAT = 1, out_valid first rises in cycle 3.
- Sustained throughput with out_ready tied high: one word per RD_LAT+2 cycles (HOLD → READ → WAIT×RD_LAT).
- out_ready while out_valid = 0 has no effect. out_ready is registered-compared only in HOLD.
- A queue going non-empty during READ/WAIT is considered only at the next selection point.

## Test plan
- Reset, all queues empty, 20 cycles → q_re = 0, out_valid = 0, busy = 0 throughout.
- RD_LAT = 1, queue 2 holds 0x0ABCD, others empty, out_ready = 1 → q_re = 4'b0100 in cycle 1 only; out_valid in cycle 3 with out_data = 0x0ABCD, out_qid = 2; back to IDLE in cycle 4.
- Queues 0 and 3 each hold 3 words, STARVE_LIM = 0, out_ready = 1 → order 0,0,0,3,3,3; grants spaced by 3 cycles.
- Queue 0 holds 20 words, queue 1 holds 1 word, STARVE_LIM = 8 → queue 1 is granted as the 9th grant, then queue 0 resumes.
- out_ready held low for 10 cycles in HOLD → out_valid, out_data and out_qid stable; no further q_re until the handshake.
- rst asserted during WAIT → all outputs at reset values in the same cycle; after release with queues non-empty, a new READ starts from IDLE.

Source files
------------

// File: rtl/prio_read_scheduler.sv
// prio_read_scheduler: picks one non-empty priority FIFO per transaction
// (queue 0 highest, with an aging guard), pulses its read strobe, waits out
// the FIFO read latency, captures the word and offers it downstream.
//
// Handshake: out_valid is high whenever the captured word sits in HOLD. A
// transfer happens on a rising edge where out_valid and out_ready are both
// high. out_data/out_qid stay stable until that edge. out_ready has no effect
// while out_valid is low.
module prio_read_scheduler #(
  parameter int NUM_Q      = 4,
  parameter int DATA_W     = 21,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_Q-1:0]        q_empty,
  input  logic [NUM_Q*DATA_W-1:0] q_dout,
  output logic [NUM_Q-1:0]        q_re,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [2:0]              out_qid,
  output logic                    busy,
  output logic [1:0]              dbg_state
);

  localparam int         CNT_W = 3;
  localparam logic [3:0] LIM   = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [2:0]               g_q, g_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [2:0]               qid_q, qid_d;
  logic [NUM_Q-1:0]         q_re_q, q_re_d;
  logic [NUM_Q-1:0][3:0]    age_q, age_d;

  logic                     sel_found;
  logic [2:0]               sel_idx;
  logic                     starve_found;
  logic [2:0]               starve_idx;
  logic                     grant;
  logic [DATA_W-1:0]        rd_word;

  // Selection: a starved non-empty queue wins, else lowest non-empty index.
  always_comb begin
    sel_found    = 1'b0;
    sel_idx      = '0;
    starve_found = 1'b0;
    starve_idx   = '0;
    for (int i = NUM_Q - 1; i >= 0; i--) begin
      if (!q_empty[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        if ((STARVE_LIM > 0) && (age_q[i] == LIM)) begin
          starve_found = 1'b1;
          starve_idx   = 3'(i);
        end
      end
    end
    if (starve_found) sel_idx = starve_idx;
  end

  // Read-data mux for the currently granted queue.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (g_q == 3'(i)) rd_word = q_dout[i*DATA_W +: DATA_W];
    end
  end

  // Next-state logic; q_empty is only looked at in IDLE and at the HOLD handshake.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    qid_d   = qid_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d  = rd_word;
          qid_d   = g_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (sel_found) begin
            grant   = 1'b1;
            state_d = READ;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) g_d = sel_idx;
  end

  // Read strobe for the cycle after a grant, and age bookkeeping at grants.
  always_comb begin
    q_re_d = '0;
    age_d  = age_q;
    for (int i = 0; i < NUM_Q; i++) begin
      if (grant && (sel_idx == 3'(i))) q_re_d[i] = 1'b1;
      if (grant) begin
        if (q_empty[i] || (sel_idx == 3'(i))) begin
          age_d[i] = '0;
        end else if (age_q[i] < LIM) begin
          age_d[i] = age_q[i] + 4'd1;
        end
      end
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      qid_q   <= '0;
      q_re_q  <= '0;
      age_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      qid_q   <= qid_d;
      q_re_q  <= q_re_d;
      age_q   <= age_d;
    end
  end

  assign q_re      = q_re_q;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_qid   = qid_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_read_scheduler.sv
// Directed bench for prio_read_scheduler with a small behavioural FIFO bank
// (one-cycle read latency) and a scoreboard of expected {qid, data} words.
module tb_prio_read_scheduler;
  localparam int NUM_Q  = 4;
  localparam int DATA_W = 21;
  localparam int DEPTH  = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_Q-1:0]        q_empty;
  logic [NUM_Q*DATA_W-1:0] q_dout;
  logic [NUM_Q-1:0]        q_re;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [2:0]              out_qid;
  logic                    busy;
  logic [1:0]              dbg_state;

  logic [DATA_W-1:0] mem [NUM_Q][DEPTH];
  int                wr_ptr [NUM_Q];
  int                rd_ptr [NUM_Q] = '{default: 0};
  logic [DATA_W-1:0] dout_r [NUM_Q] = '{default: '0};
  int                cyc = 0;
  logic              bad_re = 1'b0;

  int checks;
  int errors;
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int g_idx[$];
  int g_cyc[$];
  int s2_ord[6] = '{0, 0, 0, 3, 3, 3};

  prio_read_scheduler #(
    .NUM_Q(NUM_Q), .DATA_W(DATA_W), .RD_LAT(1), .STARVE_LIM(8)
  ) dut (
    .clk(clk), .rst(rst), .q_empty(q_empty), .q_dout(q_dout), .q_re(q_re),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_qid(out_qid), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // FIFO bank model: a read sampled at an edge shows up on q_dout right after it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_Q; i++) begin
      if (q_re[i] && (rd_ptr[i] != wr_ptr[i])) begin
        dout_r[i] <= mem[i][rd_ptr[i] % DEPTH];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      q_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      q_dout[i*DATA_W +: DATA_W] = dout_r[i];
    end
  end

  // Monitor: logs grants and accepted words, flags illegal read strobes.
  always @(negedge clk) begin
    if (q_re != '0) begin
      if (!$onehot(q_re) || ((q_re & q_empty) != '0)) bad_re <= 1'b1;
      for (int i = 0; i < NUM_Q; i++) begin
        if (q_re[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(cyc);
        end
      end
    end
    if (out_valid && out_ready) obs_q.push_back({out_qid, out_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int q, input logic [DATA_W-1:0] w);
    mem[q][wr_ptr[q] % DEPTH] = w;
    wr_ptr[q] = wr_ptr[q] + 1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic sb_check(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk({tag, "_word"}, {8'd0, obs_q[k]}, {8'd0, exp_q[k]});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < NUM_Q; i++) wr_ptr[i] = 0;

    // Reset values
    repeat (2) tick();
    chk("rst_q_re", {28'd0, q_re}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {11'd0, out_data}, 32'd0);
    chk("rst_qid", {29'd0, out_qid}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // All queues empty for 20 cycles: nothing happens
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_q_re", {28'd0, q_re}, 32'd0);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end

    // Single word in queue 2: exact latency
    out_ready = 1'b1;
    push(2, 21'h0ABCD);
    exp_q.push_back({3'd2, 21'h0ABCD});
    tick();
    chk("s1_c1_q_re", {28'd0, q_re}, 32'h4);
    chk("s1_c1_busy", {31'd0, busy}, 32'd1);
    chk("s1_c1_state", {30'd0, dbg_state}, 32'd1);
    tick();
    chk("s1_c2_q_re", {28'd0, q_re}, 32'd0);
    chk("s1_c2_valid", {31'd0, out_valid}, 32'd0);
    chk("s1_c2_state", {30'd0, dbg_state}, 32'd2);
    tick();
    chk("s1_c3_valid", {31'd0, out_valid}, 32'd1);
    chk("s1_c3_data", {11'd0, out_data}, 32'h0ABCD);
    chk("s1_c3_qid", {29'd0, out_qid}, 32'd2);
    tick();
    chk("s1_c4_busy", {31'd0, busy}, 32'd0);
    chk("s1_c4_valid", {31'd0, out_valid}, 32'd0);
    chk("s1_c4_state", {30'd0, dbg_state}, 32'd0);
    sb_check("s1");

    // Queues 0 and 3 with three words each: strict priority, 3-cycle spacing
    g_idx.delete();
    g_cyc.delete();
    for (int k = 0; k < 3; k++) begin
      push(0, 21'h10000 + 21'(k));
      exp_q.push_back({3'd0, 21'h10000 + 21'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      push(3, 21'h03000 + 21'(k));
      exp_q.push_back({3'd3, 21'h03000 + 21'(k)});
    end
    tick();
    wait_idle("s2_idle", 40);
    chk("s2_grants", g_idx.size(), 32'd6);
    for (int k = 0; k < 6 && k < g_idx.size(); k++) chk("s2_order", g_idx[k], s2_ord[k]);
    for (int k = 1; k < 6 && k < g_cyc.size(); k++) chk("s2_spacing", g_cyc[k] - g_cyc[k-1], 32'd3);
    sb_check("s2");

    // Aging: queue 1 forced through on the 9th grant
    g_idx.delete();
    g_cyc.delete();
    for (int k = 0; k < 20; k++) push(0, 21'h100000 + 21'(k));
    push(1, 21'h0F0F0);
    for (int k = 0; k < 8; k++) exp_q.push_back({3'd0, 21'h100000 + 21'(k)});
    exp_q.push_back({3'd1, 21'h0F0F0});
    for (int k = 8; k < 20; k++) exp_q.push_back({3'd0, 21'h100000 + 21'(k)});
    tick();
    wait_idle("s3_idle", 100);
    chk("s3_grants", g_idx.size(), 32'd21);
    for (int k = 0; k < 21 && k < g_idx.size(); k++) chk("s3_order", g_idx[k], (k == 8) ? 32'd1 : 32'd0);
    sb_check("s3");

    // Backpressure: HOLD stays stable, no further read until the handshake
    out_ready = 1'b0;
    push(0, 21'h0BEEF);
    push(1, 21'h12345);
    exp_q.push_back({3'd0, 21'h0BEEF});
    exp_q.push_back({3'd1, 21'h12345});
    tick();
    chk("s4_c1_q_re", {28'd0, q_re}, 32'h1);
    tick();
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("s4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("s4_hold_data", {11'd0, out_data}, 32'h0BEEF);
      chk("s4_hold_qid", {29'd0, out_qid}, 32'd0);
      chk("s4_hold_q_re", {28'd0, q_re}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("s4_b2b_q_re", {28'd0, q_re}, 32'h2);
    chk("s4_b2b_valid", {31'd0, out_valid}, 32'd0);
    chk("s4_b2b_state", {30'd0, dbg_state}, 32'd1);
    wait_idle("s4_idle", 20);
    sb_check("s4");

    // Reset during WAIT: immediate abort, popped word lost, restart from IDLE
    push(3, 21'h0AAAA);
    push(3, 21'h0BBBB);
    exp_q.push_back({3'd3, 21'h0BBBB});
    tick();
    chk("s5_c1_q_re", {28'd0, q_re}, 32'h8);
    tick();
    chk("s5_c2_state", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    chk("s5_rst_q_re", {28'd0, q_re}, 32'd0);
    chk("s5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("s5_rst_busy", {31'd0, busy}, 32'd0);
    chk("s5_rst_data", {11'd0, out_data}, 32'd0);
    chk("s5_rst_qid", {29'd0, out_qid}, 32'd0);
    chk("s5_rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("s5_restart_q_re", {28'd0, q_re}, 32'h8);
    wait_idle("s5_idle", 20);
    sb_check("s5");

    chk("no_bad_re", {31'd0, bad_re}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
